// File: rtl/ldpc_syndrome_checker.sv
// LDPC syndrome checker: rotates lifted H entries and XOR-accumulates them per parity row.
// Define LDPC_SYNDROME_VEC_EN to add the per-row failure vector output row_fail_vec.
module ldpc_syndrome_checker #(
    parameter int MAX_ZC  = 384,
    parameter int SHIFT_W = 9,
    parameter int ROW_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         cfg_bg,
    input  logic [9:0]         cfg_zc,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [MAX_ZC-1:0]  in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    input  logic               in_last,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ROW_W-1:0]   fail_count,
    output logic [ROW_W-1:0]   first_fail_row,
`ifdef LDPC_SYNDROME_VEC_EN
    output logic [45:0]        row_fail_vec,
`endif
    output logic               cfg_err
);

    localparam int ZC_W = 10;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic logic zc_legal(input logic [ZC_W-1:0] z);
        logic ok;
        ok = 1'b0;
        case (z)
            10'd2,   10'd4,   10'd8,   10'd16,  10'd32,
            10'd64,  10'd128, 10'd256,
            10'd3,   10'd6,   10'd12,  10'd24,  10'd48,
            10'd96,  10'd192, 10'd384,
            10'd5,   10'd10,  10'd20,  10'd40,  10'd80,
            10'd160, 10'd320,
            10'd7,   10'd14,  10'd28,  10'd56,  10'd112,
            10'd224,
            10'd9,   10'd18,  10'd36,  10'd72,  10'd144,
            10'd288,
            10'd11,  10'd22,  10'd44,  10'd88,  10'd176,
            10'd352,
            10'd13,  10'd26,  10'd52,  10'd104, 10'd208,
            10'd15,  10'd30,  10'd60,  10'd120, 10'd240:
                ok = 1'b1;
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t state_q;
    state_t state_d;

    logic [ZC_W-1:0]   zc_q;
    logic [ROW_W-1:0]  rows_m1_q;
    logic [ROW_W-1:0]  in_row_q;
    logic              feed_done_q;

    logic              s1_valid_q;
    logic              s1_last_q;
    logic [MAX_ZC-1:0] s1_rot_q;

    logic [MAX_ZC-1:0] acc_q;
    logic [ROW_W-1:0]  s2_row_q;

    logic              cfg_ok;
    logic              start_acc;
    logic              start_bad;
    logic              beat;
    logic [ZC_W-1:0]   shift_ext;
    logic              shift_bad;
    logic [ZC_W-1:0]   shift_eff;
    logic [MAX_ZC-1:0] zc_mask;
    logic [MAX_ZC-1:0] data_m;
    logic [MAX_ZC-1:0] rot_d;
    logic [MAX_ZC-1:0] syn;
    logic              row_end;
    logic              row_bad;
    logic              final_row;
    logic [ROW_W-1:0]  fc_next;

    assign cfg_ok    = zc_legal(cfg_zc) && (cfg_bg == 2'd1 || cfg_bg == 2'd2);
    assign start_acc = (state_q == IDLE) && start && cfg_ok;
    assign start_bad = (state_q == IDLE) && start && !cfg_ok;
    assign beat      = in_valid && in_ready;

    // Out-of-range shifts pass the block through unrotated.
    assign shift_ext = ZC_W'(in_shift);
    assign shift_bad = shift_ext >= zc_q;
    assign shift_eff = shift_bad ? '0 : shift_ext;

    assign zc_mask = ~({MAX_ZC{1'b1}} << zc_q);
    assign data_m  = in_data & zc_mask;
    assign rot_d   = ((data_m >> shift_eff)
                     | (data_m << (zc_q - shift_eff))) & zc_mask;

    assign syn       = acc_q ^ s1_rot_q;
    assign row_end   = s1_valid_q && s1_last_q;
    assign row_bad   = row_end && (|syn);
    assign final_row = row_end && (s2_row_q == rows_m1_q);
    assign fc_next   = (row_bad && fail_count != '1)
                     ? fail_count + 1'b1 : fail_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = !feed_done_q;
                if (final_row) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Input-side row tracking closes the intake once the final row's last beat is in.
    always_ff @(posedge clk) begin
        if (rst) begin
            zc_q        <= '0;
            rows_m1_q   <= '0;
            in_row_q    <= '0;
            feed_done_q <= 1'b0;
        end else if (start_acc) begin
            zc_q        <= cfg_zc;
            rows_m1_q   <= (cfg_bg == 2'd1) ? ROW_W'(45) : ROW_W'(41);
            in_row_q    <= '0;
            feed_done_q <= 1'b0;
        end else if (beat && in_last) begin
            if (in_row_q == rows_m1_q) begin
                feed_done_q <= 1'b1;
            end else begin
                in_row_q <= in_row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_rot_q   <= '0;
        end else begin
            s1_valid_q <= beat;
            if (beat) begin
                s1_rot_q  <= rot_d;
                s1_last_q <= in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            s2_row_q <= '0;
        end else if (start_acc) begin
            acc_q    <= '0;
            s2_row_q <= '0;
        end else if (s1_valid_q) begin
            if (s1_last_q) begin
                acc_q    <= '0;
                s2_row_q <= s2_row_q + 1'b1;
            end else begin
                acc_q <= syn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_row <= '0;
        end else begin
            done <= final_row;
            if (start_acc) begin
                pass           <= 1'b0;
                fail_count     <= '0;
                first_fail_row <= '0;
            end else if (row_end) begin
                fail_count <= fc_next;
                if (row_bad && fail_count == '0) begin
                    first_fail_row <= s2_row_q;
                end
                if (final_row) begin
                    pass <= (fc_next == '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (start_acc) begin
            cfg_err <= 1'b0;
        end else if (start_bad) begin
            cfg_err <= 1'b1;
        end else if (beat && shift_bad) begin
            cfg_err <= 1'b1;
        end
    end

`ifdef LDPC_SYNDROME_VEC_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            row_fail_vec <= '0;
        end else if (start_acc) begin
            row_fail_vec <= '0;
        end else if (row_bad) begin
            row_fail_vec[s2_row_q] <= 1'b1;
        end
    end
`endif

endmodule
